// File: rtl/debounce_bank.sv
// Multi-channel debouncer: synchroniser, consecutive-stable-sample filter and
// one-cycle rise/fall/long-press strobes per channel, all outputs registered.
module debounce_bank #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 240000,
  parameter int HOLD_CYCLES   = 24000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] raw,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] hold,
  output logic [CHANNELS-1:0] held
);

  localparam int SW = $clog2(STABLE_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_CYCLES - 1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_r;
    logic [SW-1:0]          stab_cnt_r;
    logic [HW-1:0]          hold_cnt_r;
    logic                   clean_r, rise_r, fall_r, hold_r, held_r;
    logic                   s_s, diff_s, qual_s, fall_now_s;

    assign s_s        = sync_r[SYNC_STAGES-1];
    assign diff_s     = s_s ^ clean_r;
    assign qual_s     = diff_s & (stab_cnt_r == STABLE_MAX);
    assign fall_now_s = qual_s & clean_r;

    // Metastability chain on the raw pin
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_r <= '0;
      end else begin
        sync_r <= {sync_r[SYNC_STAGES-2:0], raw[i]};
      end
    end

    // Stable filter: any agreeing sample restarts qualification
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stab_cnt_r <= '0;
        clean_r    <= 1'b0;
        rise_r     <= 1'b0;
        fall_r     <= 1'b0;
      end else begin
        rise_r <= qual_s & ~clean_r;
        fall_r <= fall_now_s;
        if (qual_s) begin
          clean_r    <= s_s;
          stab_cnt_r <= '0;
        end else if (diff_s) begin
          stab_cnt_r <= stab_cnt_r + SW'(1);
        end else begin
          stab_cnt_r <= '0;
        end
      end
    end

    // Long-press tracker; a fall on the threshold edge suppresses the hold
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_cnt_r <= '0;
        hold_r     <= 1'b0;
        held_r     <= 1'b0;
      end else begin
        hold_r <= 1'b0;
        if (!clean_r || fall_now_s) begin
          hold_cnt_r <= '0;
          held_r     <= 1'b0;
        end else if (!held_r) begin
          if (hold_cnt_r == HOLD_MAX) begin
            hold_r <= 1'b1;
            held_r <= 1'b1;
          end else begin
            hold_cnt_r <= hold_cnt_r + HW'(1);
          end
        end
      end
    end

    assign clean[i] = clean_r;
    assign rise[i]  = rise_r;
    assign fall[i]  = fall_r;
    assign hold[i]  = hold_r;
    assign held[i]  = held_r;
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank: a raw-history reference model pushes
// expected outputs per edge, compared on the following falling edge.
module tb_debounce_bank;

  localparam int CH   = 4;
  localparam int SYNC = 2;
  localparam int STAB = 4;
  localparam int HOLD = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] raw;
  logic [CH-1:0] clean, rise, fall, hold, held;

  always #5 clk = ~clk;

  debounce_bank #(
    .CHANNELS(CH), .SYNC_STAGES(SYNC), .STABLE_CYCLES(STAB), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .raw(raw),
    .clean(clean), .rise(rise), .fall(fall), .hold(hold), .held(held)
  );

  typedef struct packed {
    logic [CH-1:0] clean;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] hold;
    logic [CH-1:0] held;
  } exp_t;

  exp_t          sb_q[$];
  logic [CH-1:0] raw_h [0:SYNC+STAB-1];
  logic [CH-1:0] m_clean, m_held;
  int            m_edge;
  int            m_rise_edge [CH];

  int num_checks = 0;
  int num_errors = 0;
  int last_rise [CH];
  int last_fall [CH];
  int last_hold [CH];
  int rise_cnt  [CH];
  int fall_cnt  [CH];
  int hold_cnt  [CH];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < SYNC + STAB; k++) raw_h[k] = '0;
    m_clean = '0;
    m_held  = '0;
    m_edge  = 0;
    for (int c = 0; c < CH; c++) m_rise_edge[c] = -1000;
  endtask

  // clean flips once the last STAB synchronised samples all disagree with it
  task automatic model_edge(input logic [CH-1:0] r);
    exp_t e;
    logic prev, flip;
    for (int k = SYNC + STAB - 1; k > 0; k--) raw_h[k] = raw_h[k-1];
    raw_h[0] = r;
    m_edge++;
    e = '0;
    for (int c = 0; c < CH; c++) begin
      prev = m_clean[c];
      flip = 1'b1;
      for (int j = SYNC; j < SYNC + STAB; j++) begin
        if (raw_h[j][c] == prev) flip = 1'b0;
      end
      e.rise[c]  = flip & ~prev;
      e.fall[c]  = flip & prev;
      m_clean[c] = prev ^ flip;
      if (e.rise[c]) m_rise_edge[c] = m_edge;
      if (prev && !flip && !m_held[c] && (m_edge - m_rise_edge[c] == HOLD)) begin
        e.hold[c] = 1'b1;
        m_held[c] = 1'b1;
      end
      if (e.fall[c]) m_held[c] = 1'b0;
    end
    e.clean = m_clean;
    e.held  = m_held;
    sb_q.push_back(e);
  endtask

  task automatic clear_obs();
    for (int c = 0; c < CH; c++) begin
      last_rise[c] = -1; last_fall[c] = -1; last_hold[c] = -1;
      rise_cnt[c]  = 0;  fall_cnt[c]  = 0;  hold_cnt[c]  = 0;
    end
  endtask

  task automatic step(input logic [CH-1:0] r, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      raw = r;
      @(posedge clk);
      model_edge(r);
      @(negedge clk);
      if (sb_q.size() == 0) begin
        check_val("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_val($sformatf("clean@%0d", m_edge), 32'(clean), 32'(e.clean));
        check_val($sformatf("rise@%0d",  m_edge), 32'(rise),  32'(e.rise));
        check_val($sformatf("fall@%0d",  m_edge), 32'(fall),  32'(e.fall));
        check_val($sformatf("hold@%0d",  m_edge), 32'(hold),  32'(e.hold));
        check_val($sformatf("held@%0d",  m_edge), 32'(held),  32'(e.held));
      end
      for (int c = 0; c < CH; c++) begin
        if (rise[c]) begin last_rise[c] = m_edge; rise_cnt[c]++; end
        if (fall[c]) begin last_fall[c] = m_edge; fall_cnt[c]++; end
        if (hold[c]) begin last_hold[c] = m_edge; hold_cnt[c]++; end
      end
    end
  endtask

  initial begin
    int e1;
    rst_n = 1'b0;
    raw   = 4'hF;
    clear_obs();
    model_reset();

    // 1: reset holds everything low regardless of raw
    repeat (5) begin
      @(negedge clk);
      check_val("rst_out", 32'({clean, rise, fall, hold, held}), 32'd0);
    end
    rst_n = 1'b1;
    step(4'hF, 8);
    check_val("rst_rise_edge", 32'(last_rise[0]), 32'd6);
    check_val("rst_rise_cnt3", 32'(rise_cnt[3]), 32'd1);
    step(4'hF, 6);
    step(4'h0, 10);

    // 2: glitch, then bounce settling high
    clear_obs();
    step(4'h1, 3);
    step(4'h0, 8);
    check_val("glitch_rise0", 32'(rise_cnt[0]), 32'd0);
    step(4'h1, 3);
    step(4'h0, 1);
    e1 = m_edge + 1;
    step(4'h1, 8);
    check_val("bounce_lat", 32'(last_rise[0] - e1), 32'd5);
    check_val("bounce_rise_cnt", 32'(rise_cnt[0]), 32'd1);
    step(4'h1, 8);
    step(4'h0, 10);

    // 3: long press on ch1
    clear_obs();
    step(4'h2, 20);
    step(4'h0, 12);
    check_val("lp_hold_lat", 32'(last_hold[1] - last_rise[1]), 32'd10);
    check_val("lp_hold_cnt", 32'(hold_cnt[1]), 32'd1);
    check_val("lp_fall_cnt", 32'(fall_cnt[1]), 32'd1);

    // 4: fall lands on the hold threshold edge of ch2
    clear_obs();
    step(4'h4, 10);
    step(4'h0, 12);
    check_val("col_gap", 32'(last_fall[2] - last_rise[2]), 32'd10);
    check_val("col_hold_cnt", 32'(hold_cnt[2]), 32'd0);

    // 5: ch1/ch2 step together while ch3 chatters
    clear_obs();
    for (int i = 0; i < 8; i++) step((i % 2 == 1) ? 4'hE : 4'h6, 2);
    check_val("ind_same_edge", 32'(last_rise[1] - last_rise[2]), 32'd0);
    check_val("ind_rise3", 32'(rise_cnt[3]), 32'd0);
    check_val("ind_rise0", 32'(rise_cnt[0]), 32'd0);
    step(4'h0, 12);

    // 6: async reset mid-count with ch1 already clean and held
    step(4'h2, 12);
    step(4'h3, 4);
    #2 rst_n = 1'b0;
    #1 check_val("async_rst", 32'({clean, rise, fall, hold, held}), 32'd0);
    #1 rst_n = 1'b1;
    model_reset();
    clear_obs();
    step(4'h3, 10);
    check_val("rst_mid_rise0", 32'(last_rise[0]), 32'd6);
    check_val("rst_mid_rise1", 32'(last_rise[1]), 32'd6);
    step(4'h0, 8);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
